// File: rtl/wb_sd_pkg.sv
// Shared constants, state and access-type definitions for the SD host Wishbone slave.
package wb_sd_pkg;

  localparam int unsigned ADR_CMD_EXEC  = 16;
  localparam int unsigned ADR_FIFO_WR   = 17;
  localparam int unsigned ADR_FIFO_RD   = 18;
  localparam int unsigned ADR_DATA_EXEC = 19;
  localparam int unsigned NUM_REGS      = 16;

  localparam int unsigned ADR_W  = 5;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned REG_W  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StResp,
    StHold,
    StWaitCmd,
    StWaitData
  } state_e;

  typedef enum logic [2:0] {
    AccReg,
    AccCmd,
    AccFifoWr,
    AccFifoRd,
    AccData,
    AccIllegal
  } access_e;

  function automatic access_e decode_adr(input logic [ADR_W-1:0] adr);
    access_e acc;
    if (32'(adr) < NUM_REGS)               acc = AccReg;
    else if (32'(adr) == ADR_CMD_EXEC)     acc = AccCmd;
    else if (32'(adr) == ADR_FIFO_WR)      acc = AccFifoWr;
    else if (32'(adr) == ADR_FIFO_RD)      acc = AccFifoRd;
    else if (32'(adr) == ADR_DATA_EXEC)    acc = AccData;
    else                                   acc = AccIllegal;
    return acc;
  endfunction

endpackage

// File: rtl/wishbone_slave_if.sv
// Single-master Wishbone bus between the host and the SD controller slave.
interface wishbone_slave_if;
  import wb_sd_pkg::*;

  logic              strobe;
  logic              we;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              error;

  modport master (
    output strobe, we, adr, wdata,
    input  rdata, ack, error
  );

  modport slave (
    input  strobe, we, adr, wdata,
    output rdata, ack, error
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push on full is accepted only alongside a pop, pop on empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wishbone_slave.sv
// Wishbone slave for the SD host: config registers, execute ports with timeout, TX/RX FIFOs.
module wishbone_slave
  import wb_sd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned EXEC_TIMEOUT = 1024
) (
  input  logic                      wb_clock,
  input  logic                      reset,
  wishbone_slave_if.slave           bus,
  output logic [NUM_REGS*REG_W-1:0] cfg_o,
  output logic                      cmd_start_o,
  input  logic                      cmd_done_i,
  output logic                      data_start_o,
  input  logic                      data_done_i,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_pop_i,
  output logic                      tx_empty_o,
  input  logic [DATA_W-1:0]         host_data_i,
  input  logic                      host_data_valid_i,
  output logic                      rx_full_o,
  output logic                      rx_overflow_o
);

  localparam int unsigned CntW = $clog2(EXEC_TIMEOUT + 1);

  state_e            state_q;
  logic [REG_W-1:0]  regs_q [NUM_REGS];
  logic              ack_q, err_q, cmd_start_q, data_start_q, rx_ovf_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CntW-1:0]   cnt_q;

  access_e           acc;
  logic              idle_req, tx_bus_push, rx_bus_pop, rx_ovf_set;
  logic              tx_full, rx_empty;
  logic [DATA_W-1:0] rx_head;
  logic              exec_done, first_wait;

  always_comb begin
    acc         = decode_adr(bus.adr);
    idle_req    = (state_q == StIdle) && bus.strobe;
    // A bus push into a full TX FIFO succeeds when the SD side pops in the same cycle.
    tx_bus_push = idle_req && bus.we && (acc == AccFifoWr) && (!tx_full || tx_pop_i);
    rx_bus_pop  = idle_req && !bus.we && (acc == AccFifoRd) && !rx_empty;
    rx_ovf_set  = host_data_valid_i && rx_full_o && !rx_bus_pop;
    exec_done   = (state_q == StWaitCmd) ? cmd_done_i : data_done_i;
    // Done is ignored while the start pulse is still out.
    first_wait  = cmd_start_q || data_start_q;
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (wb_clock),
    .rst_n (reset),
    .push  (tx_bus_push),
    .pop   (tx_pop_i),
    .wdata (bus.wdata),
    .head  (tx_data_o),
    .full  (tx_full),
    .empty (tx_empty_o)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (wb_clock),
    .rst_n (reset),
    .push  (host_data_valid_i),
    .pop   (rx_bus_pop),
    .wdata (host_data_i),
    .head  (rx_head),
    .full  (rx_full_o),
    .empty (rx_empty)
  );

  always_ff @(posedge wb_clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      cmd_start_q  <= 1'b0;
      data_start_q <= 1'b0;
      rx_ovf_q     <= 1'b0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      cmd_start_q  <= 1'b0;
      data_start_q <= 1'b0;
      if (rx_ovf_set) rx_ovf_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (bus.strobe) begin
            state_q <= StResp;
            rdata_q <= '0;
            unique case (acc)
              AccReg: begin
                ack_q <= 1'b1;
                if (bus.we) regs_q[bus.adr[3:0]] <= bus.wdata[REG_W-1:0];
                else        rdata_q <= {{(DATA_W-REG_W){1'b0}}, regs_q[bus.adr[3:0]]};
              end
              AccCmd: begin
                if (bus.we) begin
                  state_q     <= StWaitCmd;
                  cmd_start_q <= 1'b1;
                  cnt_q       <= '0;
                end else begin
                  err_q <= 1'b1;
                end
              end
              AccData: begin
                if (bus.we) begin
                  state_q      <= StWaitData;
                  data_start_q <= 1'b1;
                  cnt_q        <= '0;
                end else begin
                  err_q <= 1'b1;
                end
              end
              AccFifoWr: begin
                if (tx_bus_push) ack_q <= 1'b1;
                else             err_q <= 1'b1;
              end
              AccFifoRd: begin
                if (rx_bus_pop) begin
                  ack_q   <= 1'b1;
                  rdata_q <= rx_head;
                end else begin
                  err_q <= 1'b1;
                end
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        StWaitCmd, StWaitData: begin
          cnt_q <= cnt_q + CntW'(1);
          if (!first_wait && exec_done) begin
            ack_q   <= 1'b1;
            state_q <= StResp;
          end else if (cnt_q == CntW'(EXEC_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          rdata_q <= '0;
          state_q <= StHold;
        end
        StHold: begin
          if (!bus.strobe) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cfg
    assign cfg_o[REG_W*k +: REG_W] = regs_q[k];
  end

  assign bus.ack       = ack_q;
  assign bus.error     = err_q;
  assign bus.rdata     = rdata_q;
  assign cmd_start_o   = cmd_start_q;
  assign data_start_o  = data_start_q;
  assign rx_overflow_o = rx_ovf_q;

endmodule

// File: tb/tb_wishbone_slave.sv
// Randomized bench for wishbone_slave against a queue/array model of the register map and FIFOs.
module tb_wishbone_slave;
  import wb_sd_pkg::*;

  localparam int unsigned Depth   = 8;
  localparam int unsigned Timeout = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] cfg;
  logic         cmd_start, cmd_done, data_start, data_done;
  logic [127:0] tx_data, host_data;
  logic         tx_pop, tx_empty, host_valid, rx_full, rx_ovf;

  always #5 clk = ~clk;

  wishbone_slave_if bus ();

  wishbone_slave #(
    .FIFO_DEPTH   (Depth),
    .EXEC_TIMEOUT (Timeout)
  ) dut (
    .wb_clock          (clk),
    .reset             (rst_n),
    .bus               (bus),
    .cfg_o             (cfg),
    .cmd_start_o       (cmd_start),
    .cmd_done_i        (cmd_done),
    .data_start_o      (data_start),
    .data_done_i       (data_done),
    .tx_data_o         (tx_data),
    .tx_pop_i          (tx_pop),
    .tx_empty_o        (tx_empty),
    .host_data_i       (host_data),
    .host_data_valid_i (host_valid),
    .rx_full_o         (rx_full),
    .rx_overflow_o     (rx_ovf)
  );

  // Reference model
  logic [31:0]  m_regs [16];
  logic [127:0] m_tx [$];
  logic [127:0] m_rx [$];
  bit           m_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_regs[k] = '0;
    m_tx.delete();
    m_rx.delete();
    m_ovf = 1'b0;
  endtask

  task automatic check_status();
    logic [511:0] e;
    for (int k = 0; k < 16; k++) e[32*k +: 32] = m_regs[k];
    check("cfg", cfg, e);
    check("tx_empty", tx_empty, m_tx.size() == 0);
    check("rx_full", rx_full, m_rx.size() == Depth);
    check("rx_overflow", rx_ovf, m_ovf);
    if (m_tx.size() > 0) check("tx_head", tx_data, m_tx[0]);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Plain (non-execute) access; sd_pop drives tx_pop_i in the same cycle.
  task automatic bus_access(input bit we, input logic [4:0] adr, input logic [127:0] wd,
                            input bit sd_pop);
    bit           exp_ack;
    logic [127:0] exp_data;
    int           lat;
    exp_data = '0;
    if (sd_pop && m_tx.size() > 0) void'(m_tx.pop_front());
    if (adr < 16) begin
      exp_ack = 1'b1;
      if (we) m_regs[adr] = wd[31:0];
      else    exp_data = {96'b0, m_regs[adr]};
    end else if (adr == 17) begin
      exp_ack = we && (m_tx.size() < Depth);
      if (exp_ack) m_tx.push_back(wd);
    end else if (adr == 18) begin
      exp_ack = !we && (m_rx.size() > 0);
      if (exp_ack) exp_data = m_rx.pop_front();
    end else begin
      exp_ack = 1'b0;
    end
    bus.strobe = 1'b1;
    bus.we     = we;
    bus.adr    = adr;
    bus.wdata  = wd;
    tx_pop     = sd_pop;
    lat = 0;
    do begin
      @(negedge clk);
      tx_pop = 1'b0;
      lat++;
    end while (!(bus.ack || bus.error) && lat < 8);
    check("latency", lat, 1);
    check("ack", bus.ack, exp_ack);
    check("error", bus.error, !exp_ack);
    check("rdata", bus.rdata, exp_data);
    bus.strobe = 1'b0;
    @(negedge clk);
    check("single_pulse", {bus.ack, bus.error, bus.rdata}, '0);
    @(negedge clk);
  endtask

  // Execute access; done is raised d cycles after the start pulse (d = 0: during it).
  task automatic exec(input bit is_data, input int d);
    bit exp_ack;
    int exp_idx, got;
    bus.strobe = 1'b1;
    bus.we     = 1'b1;
    bus.adr    = is_data ? 5'd19 : 5'd16;
    bus.wdata  = rand128();
    @(negedge clk);
    check("start_pulse", {cmd_start, data_start}, is_data ? 2'b01 : 2'b10);
    exp_ack = (d >= 1) && (d <= int'(Timeout) - 1);
    exp_idx = exp_ack ? d + 1 : int'(Timeout);
    got = 0;
    for (int i = 1; i <= int'(Timeout) + 10; i++) begin
      if (i == d + 1) begin
        if (is_data) data_done = 1'b1;
        else         cmd_done = 1'b1;
      end
      @(negedge clk);
      cmd_done  = 1'b0;
      data_done = 1'b0;
      if (bus.ack || bus.error) begin
        got = i;
        break;
      end
    end
    check("exec_latency", got, exp_idx);
    check("exec_ack", bus.ack, exp_ack);
    check("exec_error", bus.error, !exp_ack);
    bus.strobe = 1'b0;
    @(negedge clk);
    check("exec_single_pulse", {bus.ack, bus.error, cmd_start, data_start}, '0);
    @(negedge clk);
  endtask

  task automatic host_push(input logic [127:0] v);
    host_data  = v;
    host_valid = 1'b1;
    if (m_rx.size() < Depth) m_rx.push_back(v);
    else                     m_ovf = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic sd_pop_one();
    if (m_tx.size() > 0) void'(m_tx.pop_front());
    tx_pop = 1'b1;
    @(negedge clk);
    tx_pop = 1'b0;
  endtask

  initial begin
    int acks, bad;
    bus.strobe = 1'b0;
    bus.we     = 1'b0;
    bus.adr    = '0;
    bus.wdata  = '0;
    cmd_done   = 1'b0;
    data_done  = 1'b0;
    tx_pop     = 1'b0;
    host_data  = '0;
    host_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.ack, bus.error, bus.rdata, cmd_start, data_start, rx_ovf}, '0);
    check("reset_cfg", cfg, '0);
    check("reset_fifo_flags", {tx_empty, rx_full}, 2'b10);
    rst_n = 1'b1;
    @(negedge clk);

    // Register path
    bus_access(1'b1, 5'd5, 128'hDEADBEEF, 1'b0);
    bus_access(1'b0, 5'd5, '0, 1'b0);
    check("cfg_reg5", cfg[191:160], 32'hDEADBEEF);

    // TX fill past full, then drain in order
    for (int i = 0; i <= int'(Depth); i++) bus_access(1'b1, 5'd17, 128'(4 + 5 * i), 1'b0);
    check_status();
    for (int i = 0; i < int'(Depth); i++) begin
      check("tx_drain", tx_data, 128'(4 + 5 * i));
      sd_pop_one();
    end
    check("tx_drained_empty", tx_empty, 1'b1);

    // Full TX with a same-cycle SD pop accepts the bus push
    for (int i = 0; i < int'(Depth); i++) bus_access(1'b1, 5'd17, rand128(), 1'b0);
    bus_access(1'b1, 5'd17, rand128(), 1'b1);
    check_status();
    while (m_tx.size() > 0) sd_pop_one();

    // RX empty read, then overflow and in-order drain
    bus_access(1'b0, 5'd18, '0, 1'b0);
    for (int i = 0; i <= int'(Depth); i++) host_push(128'(100 + i));
    check("rx_overflow_set", rx_ovf, 1'b1);
    check_status();
    for (int i = 0; i < int'(Depth); i++) bus_access(1'b0, 5'd18, '0, 1'b0);
    check_status();

    // Execute ports: normal, timeout, done during start pulse, done on timeout edge
    exec(1'b0, 5);
    exec(1'b1, int'(Timeout) + 100);
    exec(1'b0, 0);
    exec(1'b1, int'(Timeout) - 1);

    // Illegal directions / addresses
    bus_access(1'b0, 5'd16, '0, 1'b0);
    bus_access(1'b0, 5'd17, '0, 1'b0);
    bus_access(1'b1, 5'd18, rand128(), 1'b0);
    bus_access(1'b1, 5'd25, rand128(), 1'b0);
    check_status();

    // Strobe held for 10 cycles is answered once
    bus.strobe = 1'b1;
    bus.we     = 1'b0;
    bus.adr    = 5'd3;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      acks += int'(bus.ack) + int'(bus.error);
    end
    bus.strobe = 1'b0;
    check("held_strobe_pulses", acks, 1);
    repeat (2) @(negedge clk);

    // Reset while waiting on a command
    bus.strobe = 1'b1;
    bus.we     = 1'b1;
    bus.adr    = 5'd16;
    repeat (3) @(negedge clk);
    rst_n      = 1'b0;
    bus.strobe = 1'b0;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      bad += int'(bus.ack) + int'(bus.error);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      bad += int'(bus.ack) + int'(bus.error);
    end
    check("reset_abandons", bad, 0);
    check_status();
    bus_access(1'b0, 5'd5, '0, 1'b0);

    // Randomized traffic
    repeat (300) begin
      int op;
      logic [4:0] a;
      op = $urandom_range(0, 7);
      unique case (op)
        0: bus_access(1'b1, 5'($urandom_range(0, 15)), rand128(), 1'b0);
        1: bus_access(1'b0, 5'($urandom_range(0, 15)), '0, 1'b0);
        2: bus_access(1'b1, 5'd17, rand128(), 1'($urandom_range(0, 3) == 0));
        3: sd_pop_one();
        4: host_push(rand128());
        5: bus_access(1'b0, 5'd18, '0, 1'b0);
        6: begin
          a = 5'($urandom_range(16, 31));
          if (a == 5'd16 || a == 5'd19 || a == 5'd17) bus_access(1'b0, a, '0, 1'b0);
          else if (a == 5'd18) bus_access(1'b1, a, rand128(), 1'b0);
          else bus_access(1'($urandom_range(0, 1)), a, rand128(), 1'b0);
        end
        default: exec(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      endcase
      check_status();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
